// File: rtl/alu_iterative_exec.sv
// Iterative ALU: runs a 4-bit ALUOperation on operands latched at accept; SLL/SRL move one bit per cycle.
// Latency: 1 edge for logic/add/sub/illegal/zero-shift, shamt+1 edges for shifts with shamt>0.
// Backpressure: start is accepted only while busy=0; requests seen while busy are dropped, not queued.
module alu_iterative_exec #(
    parameter int WIDTH       = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       ALUResult,
    output logic                   Zero,
    output logic                   illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Completion record: everything that becomes visible together at done.
    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             zero;
        logic             illegal;
    } res_t;

    state_t                 state_q, state_nxt;
    res_t                   res_q, res_nxt, op_res;
    logic [WIDTH-1:0]       w_q, w_nxt, w_step;
    logic [SHAMT_WIDTH-1:0] c_q, c_nxt;
    logic                   dir_q, dir_nxt;   // 1 = shift right
    logic                   is_shift;

    // Single-cycle result; shift codes only reach this path with shamt=0, so B passes through.
    always_comb begin
        op_res.value   = '0;
        op_res.illegal = 1'b0;
        case (ALUOperation)
            OP_AND:         op_res.value = A & B;
            OP_OR:          op_res.value = A | B;
            OP_NOR:         op_res.value = ~(A | B);
            OP_ADD:         op_res.value = A + B;
            OP_SUB:         op_res.value = A - B;
            OP_SLL, OP_SRL: op_res.value = B;
            default:        op_res.illegal = 1'b1;
        endcase
        op_res.zero = (op_res.value == '0);
    end

    assign is_shift = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
    assign w_step   = dir_q ? (w_q >> 1) : (w_q << 1);

    always_comb begin
        state_nxt = state_q;
        res_nxt   = res_q;
        w_nxt     = w_q;
        c_nxt     = c_q;
        dir_nxt   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        w_nxt     = B;
                        c_nxt     = shamt;
                        dir_nxt   = (ALUOperation == OP_SRL);
                        state_nxt = ST_SHIFT;
                    end else begin
                        res_nxt   = op_res;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                w_nxt = w_step;
                c_nxt = c_q - SHAMT_WIDTH'(1);
                if (c_q == SHAMT_WIDTH'(1)) begin
                    res_nxt.value   = w_step;
                    res_nxt.zero    = (w_step == '0);
                    res_nxt.illegal = 1'b0;
                    state_nxt       = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_q.value   <= '0;
            res_q.zero    <= 1'b1;
            res_q.illegal <= 1'b0;
            w_q           <= '0;
            c_q           <= '0;
            dir_q         <= 1'b0;
        end else begin
            res_q <= res_nxt;
            w_q   <= w_nxt;
            c_q   <= c_nxt;
            dir_q <= dir_nxt;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign ALUResult = res_q.value;
    assign Zero      = res_q.zero;
    assign illegal   = res_q.illegal;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Self-checking bench for alu_iterative_exec: directed cases plus random operations against a reference model.
module tb_alu_iterative_exec;
    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    ALUOperation;
    logic [W-1:0]  A, B;
    logic [SW-1:0] shamt;
    logic          busy, done, Zero, illegal;
    logic [W-1:0]  ALUResult;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_iterative_exec #(.WIDTH(W), .SHAMT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
        .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Returns {illegal, result}.
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int sh);
        case (op)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a | b};
            4'd2:    return {1'b0, ~(a | b)};
            4'd3:    return {1'b0, a + b};
            4'd4:    return {1'b0, a - b};
            4'd5:    return {1'b0, b << sh};
            4'd6:    return {1'b0, b >> sh};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic scramble();
        A            = $urandom;
        B            = $urandom;
        shamt        = SW'($urandom);
        ALUOperation = 4'($urandom);
    endtask

    // Issue one request from idle; noise=1 keeps pulsing start with junk while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit noise, input bit rel);
        logic [32:0] m;
        int exp_lat, edges, busy_cnt;
        m       = model(op, a, b, int'(sh));
        exp_lat = ((op == 4'd5 || op == 4'd6) && sh != 0) ? int'(sh) + 1 : 1;
        @(negedge clk);
        if (rel) reset = 1'b1;
        start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
        @(posedge clk);
        edges    = 1;
        busy_cnt = 0;
        #1;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            start = noise;
            scramble();
            @(posedge clk);
            edges++;
            #1;
        end
        if (busy) busy_cnt++;
        check("latency", 32'(edges), 32'(exp_lat));
        check("done", 32'(done), 32'd1);
        check("result", ALUResult, m[31:0]);
        check("zero", 32'(Zero), 32'(m[31:0] == 32'h0));
        check("illegal", 32'(illegal), 32'(m[32]));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
        start = noise;
        scramble();
        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
        check("result_hold", ALUResult, m[31:0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset = 1'b0; start = 1'b0; ALUOperation = 4'd0; A = '0; B = '0; shamt = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", ALUResult, 32'h0);
        check("rst_zero", 32'(Zero), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_done", 32'(done), 32'd0);
        check("rel_result", ALUResult, 32'h0);
        check("rel_zero", 32'(Zero), 32'd1);
        check("rel_illegal", 32'(illegal), 32'd0);

        run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b0, 1'b0);
        check("and_val", ALUResult, 32'h00F0_1234);
        run_op(4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b0, 1'b0);
        check("nor_val", ALUResult, 32'h000F_0000);
        run_op(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, 1'b0);
        check("add_wrap_zero", 32'(Zero), 32'd1);
        run_op(4'b0100, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0);
        check("sub_neg", ALUResult, 32'hFFFF_FFFE);
        run_op(4'b0100, 32'd9, 32'd9, 5'd0, 1'b0, 1'b0);
        check("beq_zero", 32'(Zero), 32'd1);
        run_op(4'b0101, 32'h0, 32'h0000_ABCD, 5'd16, 1'b0, 1'b0);
        check("lui_val", ALUResult, 32'hABCD_0000);
        run_op(4'b0110, 32'h0, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        check("srl31_val", ALUResult, 32'h0000_0001);
        run_op(4'b0101, 32'h0, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
        run_op(4'b0110, 32'h0, 32'h8765_4321, 5'd0, 1'b0, 1'b0);
        run_op(4'b0101, 32'h0, 32'hDEAD_BEEF, 5'd10, 1'b1, 1'b0);
        run_op(4'b0011, 32'd100, 32'd23, 5'd0, 1'b1, 1'b0);
        run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        check("illegal_set", 32'(illegal), 32'd1);
        run_op(4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0, 1'b0, 1'b0);
        check("illegal_clear", 32'(illegal), 32'd0);

        // Held start: accept, DONE, accept, DONE ...
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'b0011; A = 32'd3; B = 32'd4; shamt = '0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        start = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd4);
        check("b2b_result", ALUResult, 32'd7);
        @(posedge clk);
        #1;
        check("b2b_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a 20-step shift.
        @(negedge clk);
        start = 1'b1; ALUOperation = 4'b0101; A = '0; B = 32'h0000_0003; shamt = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", ALUResult, 32'h0);
        check("mid_rst_zero", 32'(Zero), 32'd1);
        check("mid_rst_illegal", 32'(illegal), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        run_op(4'b0011, 32'h1111_1111, 32'h2222_2222, 5'd0, 1'b0, 1'b1);
        run_op(4'b0101, 32'h0, 32'h0000_0003, 5'd20, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom),
                   1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_iterative_exec.md
# alu_iterative_exec

Multi-cycle execution unit that consumes the 4-bit ALUOperation code produced by the ALU control decoder. It executes that code on registered operands. Logic and add/sub operations complete in one cycle. SLL/SRL are performed one bit position per cycle, which removes the 32-bit barrel shifter from the datapath. A start/busy/done handshake lets the multi-cycle processor control FSM stall until the result and Zero flag are valid.

## Interface
- WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width; shifts of 0..2^SHAMT_WIDTH-1
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only when busy=0
- ALUOperation  input  4  operation code; sampled on accept
- A  input  WIDTH  first operand (rs); sampled on accept
- B  input  WIDTH  second operand (rt/immediate); sampled on accept
- shamt  input  SHAMT_WIDTH  shift amount; sampled on accept
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; ALUResult/Zero/illegal valid
- ALUResult  output  WIDTH  result; holds until next completion
- Zero  output  1  ALUResult == 0, registered with ALUResult
- illegal  output  1  last completed code was not supported; holds like ALUResult

## Operation
- Codes:
  - 0000 AND: A&B
  - 0001 OR: A|B
  - 0010 NOR: ~(A|B)
  - 0011 ADD: A+B
  - 0100 SUB: A-B
  - 0101 SLL: B<<shamt
  - 0110 SRL: B>>shamt, logical
- LUI arrives upstream as 0101 with shamt=16; no special handling is needed here.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. No carry or overflow output.
- Shifts: vacated bits are filled with 0.
- Any other code (e.g. 1001 decoder default, 0111, 1xxx) completes in one cycle with ALUResult=0, Zero=1, illegal=1.
- State IDLE:
  - start=1 latches the operands.
  - Non-shift code, or shift with shamt=0: register the result and go to DONE.
  - Shift with shamt>0: load working register W=B and counter C=shamt, then go to SHIFT.
- State SHIFT:
  - Each edge: shift W by 1 in the requested direction and decrement C.
  - On the edge where C==1: write the shifted value to ALUResult/Zero, clear illegal, and go to DONE.
- State DONE: done=1 for exactly this cycle; go to IDLE on the next edge.
- start is ignored in SHIFT and DONE. Requests are not queued; the requester must hold start until busy=0.
- ALUResult, Zero and illegal update only at completion. Intermediate shift values are never visible on ALUResult.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, ALUResult=0, Zero=1, illegal=0, W=0, C=0.
  - Reset mid-shift aborts the operation; no done is produced for it.

## Timing
- Latency counts edges from the accepting edge (inclusive) to the edge after which done=1:
  - Non-shift, illegal, or shamt=0: 1
  - Shift with shamt=n>0: n+1
- busy rises after the accepting edge and falls after the DONE cycle.
- Minimum start-to-start spacing is 2 cycles (accept, DONE).
- done and busy are registered outputs: no combinational path from start or ALUOperation to any output.
- Input changes after the accept edge have no effect on the operation in flight.
- start asserted in the same cycle reset deasserts: accepted on the first edge after release.

## Test plan
- Reset value and logic ops: release reset and check ALUResult=0, Zero=1, busy=0. Then:
  - A=0xF0F0_1234, B=0x0FF0_FFFF, code 0000 -> done one cycle after accept, ALUResult=0x00F0_1234.
  - Same operands, code 0010 -> ALUResult=0x000F_0000.
- ADD/SUB wrap and Zero:
  - 0xFFFF_FFFF + 0x0000_0001 -> ALUResult=0, Zero=1.
  - SUB 5-7 -> 0xFFFF_FFFE, Zero=0.
  - SUB 9-9 -> Zero=1, modelling a beq taken.
- LUI/shift latency:
  - code 0101, B=0x0000_ABCD, shamt=16 -> done exactly 17 edges after accept, ALUResult=0xABCD_0000, busy high for 17 cycles.
  - code 0110, B=0x8000_0000, shamt=31 -> 0x0000_0001 after 32 edges.
  - shamt=0 -> 1 edge, ALUResult=B.
- Handshake:
  - Pulse start with new operands during SHIFT and during DONE -> ignored; the result equals the first request.
  - Hold start=1 continuously -> a new accept every DONE+1 cycle.
- Illegal code: code 1001 with A=B=0xFFFF_FFFF -> done after 1 edge, ALUResult=0, Zero=1, illegal=1. A following code 0001 clears illegal.
- Reset mid-operation: assert reset asynchronously (between edges) at shift step 5 of a shamt=20 SLL -> all outputs take reset values immediately and no done pulse follows. A new request after release completes normally.
